// File: rtl/pdm_decimator.sv
// -----------------------------------------------------------------------------
// pdm_decimator
//
// Drives a PDM microphone clock, captures one PDM bit per microphone clock
// period and turns the bit stream into a low-rate PCM stream. Each PCM sample
// is the number of ones among the most recent 32 captured bits. The count is
// kept as a running sum over a 32-bit sliding window. One sample is produced
// every DECIM captured bits. Samples leave through a valid/ready handshake
// that holds a single sample.
//
// Parameters
//   CLK_DIV : clk cycles per micClk half-period (2..255)
//   DECIM   : captured PDM bits per output sample (1..65535)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   micDataPDM in   serial PDM bit from the microphone
//   micClk     out  registered 50% duty clock to the microphone
//   micLRSel   out  microphone channel select, tied low
//   pcm_data   out  ones-count of the last 32 PDM bits (0..32)
//   pcm_valid  out  pcm_data holds a sample not yet taken by the consumer
//   pcm_ready  in   consumer takes pcm_data this cycle
//   overrun    out  sticky: a sample was overwritten before being taken
// -----------------------------------------------------------------------------
module pdm_decimator #(
  parameter int CLK_DIV = 50,
  parameter int DECIM   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       micDataPDM,
  output logic       micClk,
  output logic       micLRSel,
  output logic [5:0] pcm_data,
  output logic       pcm_valid,
  input  logic       pcm_ready,
  output logic       overrun
);

  localparam int         WIN_W    = 32;
  localparam logic [5:0] ONES_MAX = 6'(WIN_W);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] DEC_LAST = 16'(DECIM - 1);

  // Running ones-count update for one window shift. The bit entering the
  // window adds one and the bit leaving it subtracts one. The result is held
  // inside 0..32 so the count can never wrap. With a consistent window the
  // clamp never engages.
  function automatic logic [5:0] stepOnes(input logic [5:0] cur,
                                          input logic       bitIn,
                                          input logic       bitOut);
    logic [5:0] res;
    res = cur;
    if (bitIn && !bitOut && (cur < ONES_MAX)) begin
      res = cur + 6'd1;
    end else if (!bitIn && bitOut && (cur != 6'd0)) begin
      res = cur - 6'd1;
    end
    return res;
  endfunction

  logic [7:0]       div_cnt;
  logic [15:0]      dec_cnt;
  logic [WIN_W-1:0] win;
  logic [5:0]       ones;

  logic       divWrap;
  logic       strobe;
  logic       sampleEvent;
  logic       transfer;
  logic [5:0] onesNext;

  // The end of the micClk high phase is the microphone's stable data point.
  // We capture micDataPDM there, once per micClk period.
  assign divWrap     = (div_cnt == DIV_LAST);
  assign strobe      = divWrap && micClk;
  assign sampleEvent = strobe && (dec_cnt == DEC_LAST);
  assign transfer    = pcm_valid && pcm_ready;
  assign onesNext    = stepOnes(ones, micDataPDM, win[WIN_W-1]);

  assign micLRSel = 1'b0;

  // ---- Stage: microphone clock divider ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 8'd0;
      micClk  <= 1'b0;
    end else begin
      if (divWrap) begin
        div_cnt <= 8'd0;
        micClk  <= ~micClk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  // ---- Stage: bit capture, sliding window and decimation counter ----
  // The window carries history across sample boundaries. This makes each
  // sample a true moving count of the last 32 bits, not a block count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win     <= '0;
      ones    <= 6'd0;
      dec_cnt <= 16'd0;
    end else if (strobe) begin
      win  <= {win[WIN_W-2:0], micDataPDM};
      ones <= onesNext;
      if (dec_cnt == DEC_LAST) begin
        dec_cnt <= 16'd0;
      end else begin
        dec_cnt <= dec_cnt + 16'd1;
      end
    end
  end

  // ---- Stage: output sample register and handshake ----
  // A new sample always wins over the one being held, because the newest
  // data is the useful data. We flag overrun only when the held sample is
  // lost untaken. A transfer in the same cycle counts as taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm_data  <= 6'd0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sampleEvent) begin
        pcm_data  <= onesNext;
        pcm_valid <= 1'b1;
        if (pcm_valid && !pcm_ready) begin
          overrun <= 1'b1;
        end
      end else if (transfer) begin
        pcm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
module tb_pdm_decimator;

  localparam int CD  = 2;
  localparam int DEC = 32;
  localparam int WIN = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       micDataPDM;
  logic       micClk;
  logic       micLRSel;
  logic [5:0] pcm_data;
  logic       pcm_valid;
  logic       pcm_ready;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // reference model state: edges since reset release, strobes seen,
  // the last WIN captured bits, and the expected output register contents
  int edges;
  int strobes;
  bit hist[$];
  int expOnes;
  bit expValid;
  int expData;
  bit expOverrun;

  pdm_decimator #(.CLK_DIV(CD), .DECIM(DEC)) dut (
    .clk       (clk),
    .rst       (rst),
    .micDataPDM(micDataPDM),
    .micClk    (micClk),
    .micLRSel  (micLRSel),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int histOnes();
    int s = 0;
    foreach (hist[i]) s += int'(hist[i]);
    return s;
  endfunction

  task automatic modelReset();
    edges   = 0;
    strobes = 0;
    hist.delete();
    repeat (WIN) hist.push_back(1'b0);
    expOnes    = 0;
    expValid   = 1'b0;
    expData    = 0;
    expOverrun = 1'b0;
  endtask

  // One clk edge of the specified behaviour. A strobe happens every
  // 2*CD edges, and every DEC-th strobe produces a sample.
  task automatic modelEdge(input bit d, input bit rdy);
    bit nv;
    nv = expValid;
    edges++;
    if (expValid && rdy) nv = 1'b0;
    if (edges % (2 * CD) == 0) begin
      strobes++;
      hist.push_back(d);
      void'(hist.pop_front());
      expOnes = histOnes();
      if (strobes % DEC == 0) begin
        if (expValid && !rdy) expOverrun = 1'b1;
        expData = expOnes;
        nv = 1'b1;
      end
    end
    expValid = nv;
  endtask

  task automatic checkAll();
    chk("micClk",    micClk,    32'((edges / CD) % 2));
    chk("micLRSel",  micLRSel,  32'd0);
    chk("pcm_valid", pcm_valid, 32'(expValid));
    chk("pcm_data",  pcm_data,  32'(expData));
    chk("overrun",   overrun,   32'(expOverrun));
    chk("ones",      dut.ones,  32'(expOnes));
  endtask

  // modes: 0 const 0, 1 const 1, 2 alternating 1,0 per strobe,
  //        3 ones for the first WIN strobes then zeros, other random
  function automatic bit pickBit(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (strobes % 2) == 0;
      3:       return strobes < WIN;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic step(input int mode, input bit rdy);
    micDataPDM = pickBit(mode);
    pcm_ready  = rdy;
    @(posedge clk);
    modelEdge(micDataPDM, rdy);
    #1;
    checkAll();
  endtask

  task automatic run(input int n, input int mode, input bit rdy);
    repeat (n) step(mode, rdy);
  endtask

  // Reset asserted mid-cycle. Outputs must clear without waiting for a clock.
  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_micClk",  micClk,    32'd0);
    chk("rst_LRSel",   micLRSel,  32'd0);
    chk("rst_valid",   pcm_valid, 32'd0);
    chk("rst_data",    pcm_data,  32'd0);
    chk("rst_overrun", overrun,   32'd0);
    chk("rst_ones",    dut.ones,  32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    micDataPDM = 1'b0;
    pcm_ready  = 1'b1;
    modelReset();
    @(negedge clk);
    doReset();

    // constant ones: first sample at edge 128, next at edge 256, both 32
    run(128, 1, 1'b1);
    chk("A_valid128", pcm_valid, 32'd1);
    chk("A_data128",  pcm_data,  32'd32);
    run(128, 1, 1'b1);
    chk("A_valid256", pcm_valid, 32'd1);
    chk("A_data256",  pcm_data,  32'd32);
    chk("A_overrun",  overrun,   32'd0);

    // alternating bits give 16, constant zeros give 0
    doReset();
    run(128, 2, 1'b1);
    chk("B_data1", pcm_data, 32'd16);
    run(128, 2, 1'b1);
    chk("B_data2", pcm_data, 32'd16);
    doReset();
    run(256, 0, 1'b1);
    chk("B_zero_valid", pcm_valid, 32'd1);
    chk("B_zero_data",  pcm_data,  32'd0);

    // 32 ones then zeros: 32, mid-window 24 after 8 zeros, then 0
    doReset();
    run(128, 3, 1'b1);
    chk("C_data1", pcm_data, 32'd32);
    run(32, 3, 1'b1);
    chk("C_mid_ones", dut.ones, 32'd24);
    run(96, 3, 1'b1);
    chk("C_data2", pcm_data, 32'd0);

    // consumer stalled across two samples: overwrite and sticky overrun
    doReset();
    run(128, 3, 1'b0);
    chk("D_valid1",   pcm_valid, 32'd1);
    chk("D_data1",    pcm_data,  32'd32);
    chk("D_overrun1", overrun,   32'd0);
    run(128, 3, 1'b0);
    chk("D_valid2",   pcm_valid, 32'd1);
    chk("D_data2",    pcm_data,  32'd0);
    chk("D_overrun2", overrun,   32'd1);
    run(4, 0, 1'b1);
    chk("D_valid3",   pcm_valid, 32'd0);
    chk("D_sticky",   overrun,   32'd1);

    // ready asserted only in the second sample-event cycle
    doReset();
    run(255, 3, 1'b0);
    step(3, 1'b1);
    chk("E_valid",   pcm_valid, 32'd1);
    chk("E_data",    pcm_data,  32'd0);
    chk("E_overrun", overrun,   32'd0);

    // reset mid-run with constant ones: restart, next sample 128 edges after release
    doReset();
    run(70, 1, 1'b1);
    doReset();
    run(127, 1, 1'b1);
    chk("F_valid127", pcm_valid, 32'd0);
    step(1, 1'b1);
    chk("F_valid128", pcm_valid, 32'd1);
    chk("F_data128",  pcm_data,  32'd32);

    // random data with a mostly-stalled consumer, reset between rounds
    for (int r = 0; r < 3; r++) begin
      doReset();
      for (int i = 0; i < 700; i++) begin
        step(4, 1'(($urandom % 6) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
